interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Sequences Register_File for interrupt entry and exit. It latches 9 request lines and picks the highest-priority
//  enabled one at an instruction boundary. On entry it backs up the accumulator, links the return address, switches
//  page and masks interrupts, then loads the vector PC. On reti it undoes all of this. Sits between control unit and RF.
// PARAMETERS
//  VECTOR_BASE    16'h0010  PC of vector 0
//  VECTOR_STRIDE  16'h0004  PC distance between consecutive vectors
//  VECTOR_PAGE    4'h0      page selected while servicing
// PORTS
//  clk                    in   1   clock; all state changes on posedge
//  reset                  in   1   asynchronous, active-high reset
//  irq                    in   9   request lines, level, bit 0 = highest priority
//  irq_enable             in   9   enable mask (RF flag_output[11:3])
//  page_current           in   4   current page (RF flag_output[15:12])
//  pc_current             in   16  PC of next instruction to execute
//  return_address         in   16  RF return_address_output
//  instr_boundary         in   1   control unit is between instructions; entry allowed
//  reti                   in   1   return-from-interrupt decoded (1-cycle pulse)
//  busy                   out  1   stall control unit
//  r_backup               out  1   RF accumulator backup strobe
//  r_restore              out  1   RF accumulator restore strobe
//  return_address_write   out  1   RF return address write
//  return_address_out     out  16  RF return_address_input
//  page_write             out  1   RF page write
//  page_out               out  4   RF page_input
//  interrupt_write        out  1   RF interrupt mask write
//  interrupt_out          out  9   RF interrupt_input
//  pc_load                out  1   PC load strobe
//  pc_out                 out  16  PC load value
//  irq_ack                out  9   one-hot acknowledge pulse of the serviced line
//  in_service             out  1   a handler is running (ENTRY..EXIT inclusive)
// BEHAVIOUR
//  - Reset, any time including mid-sequence:
//    state=IDLE; pending, saved_idx, saved_pc, saved_page and saved_mask = 0; every output 0.
//  - pending[i] <= pending[i] | irq[i] on every clock.
//    A JUMP clears only the acked bit; if irq[i] is still high in that cycle, the bit stays set.
//  - Outputs are Moore decodes of state. Any strobe not listed for a state is 0.
//  - IDLE: all strobes 0.
//    If instr_boundary && |(pending & irq_enable): idx = lowest set bit;
//    capture saved_pc=pc_current, saved_page=page_current, saved_mask=irq_enable; go to BACKUP.
//  - BACKUP: busy=1, r_backup=1 -> LINK.
//  - LINK: busy=1;
//    return_address_write=1 with return_address_out=saved_pc;
//    page_write=1 with page_out=VECTOR_PAGE;
//    interrupt_write=1 with interrupt_out=0 (no nesting) -> JUMP.
//  - JUMP: busy=1; pc_load=1 with pc_out = VECTOR_BASE + idx*VECTOR_STRIDE (16-bit, wraps mod 2^16);
//    irq_ack[idx]=1; clear pending[idx] -> SERVICE.
//  - SERVICE: busy=0. reti=1 -> EXIT. New irqs only accumulate in pending.
//  - EXIT: busy=1; r_restore=1;
//    page_write=1 with page_out=saved_page;
//    interrupt_write=1 with interrupt_out=saved_mask -> RETURN.
//  - RETURN: busy=1; pc_load=1 with pc_out=return_address (RF value sampled this cycle) -> IDLE.
//  - Entry latency: boundary cycle + 3 cycles to pc_load. Exit latency: reti cycle + 2 cycles to pc_load.
//  - reti outside SERVICE is ignored. instr_boundary outside IDLE is ignored.
//  - IDLE after RETURN re-evaluates pending with the restored mask at the next boundary.
//  - A request arriving on the same edge as RETURN is not lost.
// TESTING
//  - Reset mid-LINK (assert reset in that cycle) -> all outputs 0 the same cycle; IDLE; pending=0.
//  - irq=9'h004, enable=9'h1FF, boundary, pc=0x0123, page=5:
//    BACKUP, LINK(ra_out=0x0123, page_out=0, int_out=0), JUMP(pc_out=0x0018, ack=9'h004).
//  - irq=9'h0A0, enable=9'h1FF -> idx 5 serviced, pc_out=0x0024.
//    After reti/RETURN with bit 7 pending -> next boundary services idx 7, pc_out=0x002C.
//  - irq=9'h002, enable=9'h000, boundary held 10 cycles -> stays IDLE; busy=0; pending[1]=1.
//  - In SERVICE, reti with return_address=0x0456, saved_page=5, saved_mask=0x1FF:
//    EXIT(r_restore=1, page_out=5, int_out=0x1FF), RETURN(pc_out=0x0456).
//  - reti pulse in IDLE and irq during SERVICE -> no strobes; second irq entered only after RETURN.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Drives the register file through interrupt entry and exit. Request lines are
// latched into a pending set. At an instruction boundary the lowest-numbered
// pending and enabled request is picked. Entry backs up the accumulator, links
// the return address, switches to the vector page, masks all interrupts, and
// then loads the vector PC. On reti the sequencer restores the accumulator, the
// page and the interrupt mask, then loads the PC from the register file's
// return address.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   irq[8:0]                level request lines, bit 0 = highest priority
//   irq_enable[8:0]         interrupt enable mask from the register file
//   page_current[3:0]       current page from the register file
//   pc_current[15:0]        PC of the next instruction
//   return_address[15:0]    register file return address output
//   instr_boundary          control unit sits between instructions
//   reti                    return-from-interrupt decoded (1-cycle pulse)
//   busy                    stalls the control unit
//   r_backup / r_restore    accumulator backup / restore strobes
//   return_address_write/out  return address write strobe and value
//   page_write/out          page write strobe and value
//   interrupt_write/out     interrupt mask write strobe and value
//   pc_load / pc_out        PC load strobe and value
//   irq_ack[8:0]            one-hot acknowledge of the serviced line
//   in_service              a handler sequence is in progress
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004,
    parameter logic [3:0]  VECTOR_PAGE   = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  irq,
    input  logic [8:0]  irq_enable,
    input  logic [3:0]  page_current,
    input  logic [15:0] pc_current,
    input  logic [15:0] return_address,
    input  logic        instr_boundary,
    input  logic        reti,
    output logic        busy,
    output logic        r_backup,
    output logic        r_restore,
    output logic        return_address_write,
    output logic [15:0] return_address_out,
    output logic        page_write,
    output logic [3:0]  page_out,
    output logic        interrupt_write,
    output logic [8:0]  interrupt_out,
    output logic        pc_load,
    output logic [15:0] pc_out,
    output logic [8:0]  irq_ack,
    output logic        in_service
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BACKUP,
        ST_LINK,
        ST_JUMP,
        ST_SERVICE,
        ST_EXIT,
        ST_RETURN
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  pending_q, pending_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] saved_pc_q, saved_pc_d;
    logic [3:0]  saved_page_q, saved_page_d;
    logic [8:0]  saved_mask_q, saved_mask_d;

    logic [8:0]  candidates;
    logic [3:0]  pick_idx;
    logic [8:0]  ack_onehot;
    logic [15:0] vector_pc;

    // Priority pick: scanning from the top down leaves the lowest set bit.
    always_comb begin
        candidates = pending_q & irq_enable;
        pick_idx   = '0;
        for (int i = 8; i >= 0; i--) begin
            if (candidates[i]) begin
                pick_idx = 4'(i);
            end
        end
    end

    assign ack_onehot = 9'b1 << idx_q;
    assign vector_pc  = VECTOR_BASE + ({12'd0, idx_q} * VECTOR_STRIDE);

    // Next-state logic.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        saved_pc_d   = saved_pc_q;
        saved_page_d = saved_page_q;
        saved_mask_d = saved_mask_q;
        pending_d    = pending_q | irq;

        case (state_q)
            ST_IDLE: begin
                if (instr_boundary && (|candidates)) begin
                    idx_d        = pick_idx;
                    saved_pc_d   = pc_current;
                    saved_page_d = page_current;
                    saved_mask_d = irq_enable;
                    state_d      = ST_BACKUP;
                end
            end
            ST_BACKUP: state_d = ST_LINK;
            ST_LINK:   state_d = ST_JUMP;
            ST_JUMP: begin
                // The acked bit survives when its line is still asserted now.
                pending_d = (pending_q & ~ack_onehot) | irq;
                state_d   = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT:   state_d = ST_RETURN;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; IDLE drives everything to zero.
    always_comb begin
        busy                 = 1'b0;
        r_backup             = 1'b0;
        r_restore            = 1'b0;
        return_address_write = 1'b0;
        return_address_out   = '0;
        page_write           = 1'b0;
        page_out             = '0;
        interrupt_write      = 1'b0;
        interrupt_out        = '0;
        pc_load              = 1'b0;
        pc_out               = '0;
        irq_ack              = '0;
        in_service           = (state_q != ST_IDLE);

        case (state_q)
            ST_BACKUP: begin
                busy     = 1'b1;
                r_backup = 1'b1;
            end
            ST_LINK: begin
                busy                 = 1'b1;
                return_address_write = 1'b1;
                return_address_out   = saved_pc_q;
                page_write           = 1'b1;
                page_out             = VECTOR_PAGE;
                interrupt_write      = 1'b1;
                interrupt_out        = '0;
            end
            ST_JUMP: begin
                busy    = 1'b1;
                pc_load = 1'b1;
                pc_out  = vector_pc;
                irq_ack = ack_onehot;
            end
            ST_EXIT: begin
                busy            = 1'b1;
                r_restore       = 1'b1;
                page_write      = 1'b1;
                page_out        = saved_page_q;
                interrupt_write = 1'b1;
                interrupt_out   = saved_mask_q;
            end
            ST_RETURN: begin
                busy    = 1'b1;
                pc_load = 1'b1;
                pc_out  = return_address;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    // NOTE: all state, the pending set and the saved context included, is
    // cleared by reset so a reset mid-sequence leaves no stale request behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            idx_q        <= '0;
            saved_pc_q   <= '0;
            saved_page_q <= '0;
            saved_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            saved_pc_q   <= saved_pc_d;
            saved_page_q <= saved_page_d;
            saved_mask_q <= saved_mask_d;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Scoreboard bench. The stimulus side keeps an abstract model (a pending set
// plus "entry / exit" transactions) and pushes the expected output records of
// each transaction into a queue. A negedge monitor pops one record for every
// cycle in which the DUT shows any activity and compares it.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

    localparam logic [15:0] VB = 16'h0010;
    localparam logic [15:0] VS = 16'h0004;
    localparam logic [3:0]  VP = 4'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  irq = '0;
    logic [8:0]  irq_enable = '0;
    logic [3:0]  page_current = '0;
    logic [15:0] pc_current = '0;
    logic [15:0] return_address = '0;
    logic        instr_boundary = 1'b0;
    logic        reti = 1'b0;
    logic        busy, r_backup, r_restore, return_address_write;
    logic [15:0] return_address_out;
    logic        page_write;
    logic [3:0]  page_out;
    logic        interrupt_write;
    logic [8:0]  interrupt_out;
    logic        pc_load;
    logic [15:0] pc_out;
    logic [8:0]  irq_ack;
    logic        in_service;

    interrupt_sequencer #(
        .VECTOR_BASE  (VB),
        .VECTOR_STRIDE(VS),
        .VECTOR_PAGE  (VP)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .irq                 (irq),
        .irq_enable          (irq_enable),
        .page_current        (page_current),
        .pc_current          (pc_current),
        .return_address      (return_address),
        .instr_boundary      (instr_boundary),
        .reti                (reti),
        .busy                (busy),
        .r_backup            (r_backup),
        .r_restore           (r_restore),
        .return_address_write(return_address_write),
        .return_address_out  (return_address_out),
        .page_write          (page_write),
        .page_out            (page_out),
        .interrupt_write     (interrupt_write),
        .interrupt_out       (interrupt_out),
        .pc_load             (pc_load),
        .pc_out              (pc_out),
        .irq_ack             (irq_ack),
        .in_service          (in_service)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        r_backup;
        logic        r_restore;
        logic        ra_write;
        logic [15:0] ra_out;
        logic        page_write;
        logic [3:0]  page_out;
        logic        int_write;
        logic [8:0]  int_out;
        logic        pc_load;
        logic [15:0] pc_out;
        logic [8:0]  ack;
    } rec_t;

    rec_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] pend_m = '0;   // model of latched requests
    logic [3:0] s_page = '0;   // context saved at the last entry
    logic [8:0] s_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t sample();
        rec_t r;
        r.busy       = busy;
        r.r_backup   = r_backup;
        r.r_restore  = r_restore;
        r.ra_write   = return_address_write;
        r.ra_out     = return_address_out;
        r.page_write = page_write;
        r.page_out   = page_out;
        r.int_write  = interrupt_write;
        r.int_out    = interrupt_out;
        r.pc_load    = pc_load;
        r.pc_out     = pc_out;
        r.ack        = irq_ack;
        return r;
    endfunction

    // ---------------- expected transaction records ----------------
    function automatic rec_t mk_backup();
        rec_t r = '0;
        r.busy = 1'b1; r.r_backup = 1'b1;
        return r;
    endfunction

    function automatic rec_t mk_link(input logic [15:0] pc);
        rec_t r = '0;
        r.busy = 1'b1;
        r.ra_write = 1'b1; r.ra_out = pc;
        r.page_write = 1'b1; r.page_out = VP;
        r.int_write = 1'b1; r.int_out = '0;
        return r;
    endfunction

    function automatic rec_t mk_jump(input int idx);
        rec_t r = '0;
        r.busy = 1'b1;
        r.pc_load = 1'b1;
        r.pc_out = VB + 16'(idx * VS);
        r.ack = 9'b1 << idx;
        return r;
    endfunction

    function automatic rec_t mk_exit(input logic [3:0] pg, input logic [8:0] mask);
        rec_t r = '0;
        r.busy = 1'b1; r.r_restore = 1'b1;
        r.page_write = 1'b1; r.page_out = pg;
        r.int_write = 1'b1; r.int_out = mask;
        return r;
    endfunction

    function automatic rec_t mk_return(input logic [15:0] ra);
        rec_t r = '0;
        r.busy = 1'b1; r.pc_load = 1'b1; r.pc_out = ra;
        return r;
    endfunction

    function automatic int lowest(input logic [8:0] v);
        for (int i = 0; i < 9; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock edge; the model latches whatever request lines are driven.
    task automatic tick(input bit clr, input int idx);
        @(posedge clk);
        if (clr) pend_m = (pend_m & ~(9'b1 << idx)) | irq;
        else     pend_m = pend_m | irq;
        #1;
    endtask

    // Boundary cycle in IDLE; performs the full entry if anything is eligible.
    task automatic do_entry(input logic [8:0] en, input logic [15:0] pc,
                            input logic [3:0] pg, output bit entered);
        int idx;
        irq_enable     = en;
        pc_current     = pc;
        page_current   = pg;
        instr_boundary = 1'b1;
        idx            = lowest(pend_m & en);
        entered        = (idx >= 0);
        if (entered) begin
            s_page = pg;
            s_mask = en;
            exp_q.push_back(mk_backup());
            exp_q.push_back(mk_link(pc));
            exp_q.push_back(mk_jump(idx));
        end
        tick(1'b0, 0);
        instr_boundary = 1'b0;
        if (entered) begin
            tick(1'b0, 0);
            tick(1'b0, 0);
            tick(1'b1, idx);
        end
    endtask

    // Handler body: random new requests, optional stray boundaries.
    task automatic service(input int n, input logic [8:0] irq_mask, input bit stray);
        for (int i = 0; i < n; i++) begin
            irq            = 9'($urandom) & irq_mask;
            instr_boundary = stray;
            check("service_busy", {63'd0, busy}, 64'd0);
            check("service_in_service", {63'd0, in_service}, 64'd1);
            tick(1'b0, 0);
        end
        irq            = '0;
        instr_boundary = 1'b0;
    endtask

    // reti pulse and full exit; irq_ret is driven only in the RETURN cycle.
    task automatic do_exit(input logic [15:0] ra, input logic [8:0] irq_ret);
        return_address = ra;
        reti           = 1'b1;
        exp_q.push_back(mk_exit(s_page, s_mask));
        exp_q.push_back(mk_return(ra));
        tick(1'b0, 0);
        reti = 1'b0;
        tick(1'b0, 0);
        irq = irq_ret;
        tick(1'b0, 0);
        irq = '0;
    endtask

    task automatic pulse_irq(input logic [8:0] v);
        irq = v;
        tick(1'b0, 0);
        irq = '0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        rec_t r;
        rec_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                r = sample();
                if (r != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(r), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("seq_output", 64'(r), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ent;

        // Reset state.
        #1;
        check("reset_outputs", 64'(sample()), 64'd0);
        check("reset_in_service", {63'd0, in_service}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b0, 0);

        // Single request on line 2, then exit with restored context.
        pulse_irq(9'h004);
        do_entry(9'h1FF, 16'h0123, 4'h5, ent);
        service(2, 9'h000, 1'b0);
        do_exit(16'h0456, 9'h000);
        tick(1'b0, 0);

        // Two requests: line 5 first, line 7 on the next boundary.
        pulse_irq(9'h0A0);
        do_entry(9'h1FF, 16'h0200, 4'h3, ent);
        service(3, 9'h000, 1'b0);
        do_exit(16'h0201, 9'h000);
        do_entry(9'h1FF, 16'h0300, 4'h3, ent);
        service(1, 9'h000, 1'b0);
        do_exit(16'h0301, 9'h000);

        // Disabled request stays pending through 10 boundary cycles.
        pulse_irq(9'h002);
        irq_enable     = 9'h000;
        instr_boundary = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 0);
            check("masked_busy", {63'd0, busy}, 64'd0);
            check("masked_in_service", {63'd0, in_service}, 64'd0);
        end
        instr_boundary = 1'b0;
        do_entry(9'h002, 16'h0400, 4'h1, ent);
        service(1, 9'h000, 1'b0);
        do_exit(16'h0401, 9'h000);

        // Stray reti in IDLE; request during SERVICE; request on RETURN edge.
        reti = 1'b1;
        tick(1'b0, 0);
        reti = 1'b0;
        tick(1'b0, 0);
        check("stray_reti_busy", {63'd0, busy}, 64'd0);
        pulse_irq(9'h001);
        do_entry(9'h1FF, 16'h0500, 4'h7, ent);
        irq = 9'h008;
        tick(1'b0, 0);
        irq = '0;
        service(2, 9'h000, 1'b1);
        do_exit(16'h0501, 9'h040);
        do_entry(9'h1FF, 16'h0600, 4'h2, ent);
        service(1, 9'h000, 1'b0);
        do_exit(16'h0601, 9'h000);
        do_entry(9'h1FF, 16'h0700, 4'h2, ent);
        service(1, 9'h000, 1'b0);
        do_exit(16'h0701, 9'h000);

        // Reset asserted during LINK.
        pulse_irq(9'h010);
        irq_enable     = 9'h1FF;
        instr_boundary = 1'b1;
        exp_q.push_back(mk_backup());
        exp_q.push_back(mk_link(16'h0800));
        exp_q.push_back(mk_jump(4));
        pc_current = 16'h0800;
        tick(1'b0, 0);
        instr_boundary = 1'b0;
        tick(1'b0, 0);
        reset = 1'b1;
        #1;
        check("reset_link_outputs", 64'(sample()), 64'd0);
        check("reset_link_in_service", {63'd0, in_service}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset  = 1'b0;
        pend_m = '0;
        instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 0);
            check("post_reset_idle", {63'd0, busy}, 64'd0);
        end
        instr_boundary = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            irq = 9'($urandom & $urandom & $urandom);
            repeat ($urandom_range(1, 3)) tick(1'b0, 0);
            irq = '0;
            if ($urandom_range(0, 3) == 0) begin
                reti = 1'b1;
                tick(1'b0, 0);
                reti = 1'b0;
            end
            do_entry(($urandom_range(0, 2) == 0) ? 9'h1FF : 9'($urandom),
                     16'($urandom), 4'($urandom), ent);
            if (ent) begin
                service($urandom_range(1, 5), 9'($urandom & $urandom),
                        1'($urandom_range(0, 1)));
                do_exit(16'($urandom), 9'($urandom & $urandom & $urandom));
            end
        end

        repeat (4) tick(1'b0, 0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
